// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment display blocks: scan states and
// the fixed digit / PWM phase counts.
package sseg_pkg;

    typedef enum logic {
        OFF  = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    localparam int NUM_DIGITS = 4;
    localparam int PWM_STEPS  = 8;

endpackage

// File: rtl/sseg_prescaler.sv
// Modulo-N counter with enable and synchronous clear; wrap flags the last
// count of each period while counting.
module sseg_prescaler #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_reg;

    assign count = count_reg;
    assign wrap  = en && !clr && (count_reg == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= (count_reg == LAST) ? '0 : count_reg + W'(1);
        end
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Scan sequencer for the 4-digit seven-segment datapath: digit multiplexing,
// frame-synchronous double buffering of display data and brightness PWM.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic        hex_dec_in,
    input  logic        sign_in,
    input  logic [2:0]  bright,
    output logic [15:0] data,
    output logic        hex_dec,
    output logic        sign,
    output logic [1:0]  digit_sel,
    output logic        digit_on,
    output logic        pending,
    output logic        frame_done
);

    localparam logic [1:0]   LAST_DIGIT = 2'(NUM_DIGITS - 1);
    localparam logic [CNT_W:0] PWM_STEP = (CNT_W + 1)'(REFRESH_DIV / PWM_STEPS);

    scan_state_t  state_reg;
    logic [1:0]   digit_sel_reg;
    logic         digit_on_reg;
    logic         frame_done_reg;
    logic [15:0]  data_reg;
    logic         hex_dec_reg;
    logic         sign_reg;
    logic [15:0]  shadow_data_reg;
    logic         shadow_hex_dec_reg;
    logic         shadow_sign_reg;
    logic         pending_reg;

    logic             scan_active;
    logic [CNT_W-1:0] prescale;
    logic             slot_end;
    logic             frame_end;
    logic [CNT_W:0]   pwm_thresh;
    logic             pwm_on;

    // Dropping en takes effect at once so an abandoned frame never reports done.
    assign scan_active = (state_reg == SCAN) && en;

    sseg_prescaler #(
        .N (REFRESH_DIV),
        .W (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (scan_active),
        .clr   (!scan_active),
        .count (prescale),
        .wrap  (slot_end)
    );

    assign frame_end = slot_end && (digit_sel_reg == LAST_DIGIT);

    // One extra bit so bright=7 yields exactly REFRESH_DIV without wrapping.
    assign pwm_thresh = ((CNT_W + 1)'(bright) + (CNT_W + 1)'(1)) * PWM_STEP;
    assign pwm_on     = {1'b0, prescale} < pwm_thresh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= OFF;
            digit_sel_reg      <= '0;
            digit_on_reg       <= 1'b0;
            frame_done_reg     <= 1'b0;
            data_reg           <= '0;
            hex_dec_reg        <= 1'b1;
            sign_reg           <= 1'b0;
            shadow_data_reg    <= '0;
            shadow_hex_dec_reg <= 1'b0;
            shadow_sign_reg    <= 1'b0;
            pending_reg        <= 1'b0;
        end else begin
            frame_done_reg <= frame_end;
            digit_on_reg   <= scan_active && pwm_on;

            case (state_reg)
                OFF: begin
                    digit_sel_reg <= '0;
                    if (en) begin
                        state_reg <= SCAN;
                    end
                end
                SCAN: begin
                    if (!en) begin
                        state_reg     <= OFF;
                        digit_sel_reg <= '0;
                    end else if (slot_end) begin
                        digit_sel_reg <= digit_sel_reg + 2'd1;
                    end
                end
                default: begin
                    state_reg     <= OFF;
                    digit_sel_reg <= '0;
                end
            endcase

            // Transfer reads the shadow before a same-edge load overwrites it.
            if (frame_end && pending_reg) begin
                data_reg    <= shadow_data_reg;
                hex_dec_reg <= shadow_hex_dec_reg;
                sign_reg    <= shadow_sign_reg;
            end

            if (load) begin
                shadow_data_reg    <= data_in;
                shadow_hex_dec_reg <= hex_dec_in;
                shadow_sign_reg    <= sign_in;
                pending_reg        <= 1'b1;
            end else if (frame_end) begin
                pending_reg <= 1'b0;
            end
        end
    end

    assign data       = data_reg;
    assign hex_dec    = hex_dec_reg;
    assign sign       = sign_reg;
    assign digit_sel  = digit_sel_reg;
    assign digit_on   = digit_on_reg;
    assign pending    = pending_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl: directed stimulus, expected frame updates queued
// and checked by a monitor on every frame_done pulse.
module tb_sseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] data_in;
    logic        hex_dec_in;
    logic        sign_in;
    logic [2:0]  bright;
    logic [15:0] data;
    logic        hex_dec;
    logic        sign;
    logic [1:0]  digit_sel;
    logic        digit_on;
    logic        pending;
    logic        frame_done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic        hex_dec;
        logic        sign;
        logic        pending;
    } frame_t;

    frame_t exp_q[$];
    frame_t mon_f;

    sseg_scan_ctrl #(.REFRESH_DIV(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .data_in    (data_in),
        .hex_dec_in (hex_dec_in),
        .sign_in    (sign_in),
        .bright     (bright),
        .data       (data),
        .hex_dec    (hex_dec),
        .sign       (sign),
        .digit_sel  (digit_sel),
        .digit_on   (digit_on),
        .pending    (pending),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Return 1 time unit after the clock edge that sets cyc to c.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_frame(input int c, input logic [15:0] d, input logic h,
                              input logic sg, input logic p);
        frame_t f;
        f.cyc = c; f.data = d; f.hex_dec = h; f.sign = sg; f.pending = p;
        exp_q.push_back(f);
    endtask

    task automatic do_load(input logic [15:0] d, input logic h, input logic sg);
        data_in = d; hex_dec_in = h; sign_in = sg; load = 1'b1;
        goto(cyc + 1);
        load = 1'b0;
    endtask

    task automatic measure(input logic [2:0] b);
        int x;
        int cnt;
        x = cyc;
        bright = b;
        cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            goto(x + i);
            cnt += int'(digit_on);
        end
        check($sformatf("digit_on_count_b%0d", b), cnt, int'(b) + 1);
    endtask

    // Monitor: every frame_done must match the next queued frame update.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL frame_unexpected: frame_done at cycle %0d, expected none", cyc);
                end else begin
                    mon_f = exp_q.pop_front();
                    check("frame_cycle", cyc, mon_f.cyc);
                    check("frame_data", data, mon_f.data);
                    check("frame_hex_dec", hex_dec, mon_f.hex_dec);
                    check("frame_sign", sign, mon_f.sign);
                    check("frame_pending", pending, mon_f.pending);
                    check("frame_digit_sel", digit_sel, 0);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL frame_missed: no frame_done by cycle %0d, expected at %0d", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation timed out at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        int s2;
        rst = 1'b1; en = 1'b0; load = 1'b0; data_in = '0;
        hex_dec_in = 1'b0; sign_in = 1'b0; bright = 3'd7;

        // Reset values
        goto(3);
        rst = 1'b0;
        goto(4);
        check("rst_data", data, 16'h0000);
        check("rst_hex_dec", hex_dec, 1'b1);
        check("rst_sign", sign, 1'b0);
        check("rst_digit_sel", digit_sel, 2'd0);
        check("rst_digit_on", digit_on, 1'b0);
        check("rst_pending", pending, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);

        // Scan sequencing
        goto(10);
        en = 1'b1;
        s = 11;
        push_frame(s + 32, 16'h0000, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k <= 4; k++) begin
            goto(s + 8 * k);
            check($sformatf("digit_sel_step%0d", k), digit_sel, k % 4);
        end

        // Single load mid-frame
        push_frame(s + 64, 16'h1234, 1'b1, 1'b0, 1'b0);
        goto(s + 37);
        do_load(16'h1234, 1'b1, 1'b0);
        check("load_pending", pending, 1'b1);
        check("load_data_held", data, 16'h0000);

        // Two loads in one frame: last wins
        push_frame(s + 96, 16'h5555, 1'b0, 1'b1, 1'b0);
        goto(s + 69);
        do_load(16'hAAAA, 1'b1, 1'b0);
        goto(s + 79);
        do_load(16'h5555, 1'b0, 1'b1);
        check("double_load_data_held", data, 16'h1234);

        // Load on the boundary edge while another update is pending
        push_frame(s + 128, 16'h1111, 1'b1, 1'b1, 1'b1);
        push_frame(s + 160, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        goto(s + 99);
        do_load(16'h1111, 1'b1, 1'b1);
        goto(s + 127);
        do_load(16'hBEEF, 1'b0, 1'b0);

        // Brightness sweep
        push_frame(s + 192, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        goto(s + 161);
        measure(3'd0);
        measure(3'd3);
        measure(3'd7);

        // Disable mid-frame, load while off, re-enable
        goto(s + 210);
        check("pre_off_digit_sel", digit_sel, 2'd2);
        check("pre_off_digit_on", digit_on, 1'b1);
        en = 1'b0;
        goto(s + 211);
        check("off_digit_sel", digit_sel, 2'd0);
        check("off_digit_on", digit_on, 1'b0);
        goto(s + 215);
        do_load(16'hCAFE, 1'b1, 1'b0);
        goto(s + 220);
        check("off_pending", pending, 1'b1);
        check("off_data_held", data, 16'hBEEF);
        s2 = s + 221;
        push_frame(s2 + 32, 16'hCAFE, 1'b1, 1'b0, 1'b0);
        en = 1'b1;
        goto(s2 + 8);
        check("resume_digit_sel", digit_sel, 2'd1);

        // Asynchronous reset mid-slot with an update pending
        goto(s2 + 42);
        do_load(16'h0F0F, 1'b0, 1'b1);
        goto(s2 + 45);
        check("pre_rst_pending", pending, 1'b1);
        #2;
        rst = 1'b1;
        en  = 1'b0;
        #1;
        check("arst_data", data, 16'h0000);
        check("arst_hex_dec", hex_dec, 1'b1);
        check("arst_sign", sign, 1'b0);
        check("arst_digit_sel", digit_sel, 2'd0);
        check("arst_digit_on", digit_on, 1'b0);
        check("arst_pending", pending, 1'b0);
        check("arst_frame_done", frame_done, 1'b0);
        goto(s2 + 48);
        rst = 1'b0;
        goto(s2 + 52);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
- Sequencing controller for the 4-digit seven-segment display datapath.
- Time-multiplexes the datapath by generating its `digit_sel` at a programmable refresh rate.
- Double-buffers display data, the hex/decimal mode and the sign flag, so updates only land on a frame boundary and never tear mid-scan.
- Produces a per-digit brightness enable (PWM) that the top level uses to gate the anode drive.

Parameters:
- REFRESH_DIV, 100000, clocks per digit slot; must be a multiple of 8 and at least 8.
- CNT_W, $clog2(REFRESH_DIV), prescaler counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  1 = scan enabled; 0 = display off
- load  in  1  single-cycle strobe; captures `data_in`, `hex_dec_in` and `sign_in` into the shadow registers
- data_in  in  16  new display value
- hex_dec_in  in  1  new mode; 1 = hex, 0 = BCD
- sign_in  in  1  new sign flag
- bright  in  3  brightness level 0..7; duty = (bright+1)/8
- data  out  16  active value, to datapath `data`
- hex_dec  out  1  active mode, to datapath `hex_dec`
- sign  out  1  active sign, to datapath `sign`
- digit_sel  out  2  current digit, to datapath `digit_sel`
- digit_on  out  1  1 = current digit drives; top level ANDs this into the anode enable
- pending  out  1  shadow holds an update not yet applied
- frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset values (asynchronous, rst=1):
  - state=OFF, prescaler=0, digit_sel=0, digit_on=0.
  - data=0, hex_dec=1, sign=0.
  - Shadow registers cleared; pending=0, frame_done=0.
- State machine, two states:
  - OFF: prescaler held at 0, digit_sel=0, digit_on=0. On en=1, go to SCAN on the next edge.
  - SCAN: on en=0, go to OFF on the next edge, clearing prescaler and digit_sel. Deasserting en mid-frame abandons the frame; no frame_done is issued.
- Prescaler (SCAN only):
  - Counts 0..REFRESH_DIV-1 and wraps.
  - slot_end = (prescaler == REFRESH_DIV-1).
- Digit select:
  - On slot_end, digit_sel increments and wraps 3->0.
  - Each digit is held for exactly REFRESH_DIV cycles.
  - frame = 4*REFRESH_DIV cycles.
- Frame boundary = slot_end while digit_sel==3. On that edge:
  - frame_done=1 for one cycle.
  - If pending=1: active data/hex_dec/sign <= shadow contents and pending <= 0.
  - The new values first appear with digit_sel=0.
- Load handling:
  - load=1 writes the shadow registers and sets pending=1, in any state, including OFF.
  - A load while pending=1 overwrites the shadow; the last load wins and only one update is applied.
  - Load on the same edge as a frame boundary with pending=1: the transfer uses the pre-load shadow contents; the shadow then takes the new value; pending stays 1.
  - Load on a frame-boundary edge with pending=0: no transfer this frame; pending=1.
  - In OFF there are no boundaries, so pending is held until scanning resumes.
- Brightness (registered output, SCAN only):
  - digit_on = (prescaler < (bright+1)*(REFRESH_DIV/8)), registered, so it lags the prescaler by 1 cycle.
  - bright=7 gives digit_on=1 for the whole slot, apart from the 1-cycle registered lag around slot edges.
  - bright is sampled every cycle; a change takes effect within the current slot.
- Arithmetic:
  - The product (bright+1)*(REFRESH_DIV/8) is computed at CNT_W+1 bits to avoid overflow.
  - No truncation is allowed.
- Active outputs change only at frame boundaries or on reset.

Decomposition:
- Shared display package (`sseg_pkg`) holds:
  - the state enum type `scan_state_t` {OFF, SCAN};
  - the digit-count constant NUM_DIGITS=4;
  - the PWM phase-count constant PWM_STEPS=8.
- One natural sub-module, `sseg_prescaler`: a parameterized modulo-N counter with enable and synchronous clear, producing count and the wrap pulse.
- Everything else stays in this module.

Test Plan:
All scenarios use REFRESH_DIV=8.
1. Reset, then en=1 -> digit_sel steps 0,1,2,3,0 every 8 cycles; frame_done pulses every 32 cycles; data=0, hex_dec=1 while no load has occurred.
2. Load data_in=16'h1234, hex_dec_in=1 at cycle 5 of a frame -> pending=1 immediately; data stays 0 until the frame boundary, then reads 16'h1234 with digit_sel=0 and pending=0.
3. Two loads in one frame (16'hAAAA, then 16'h5555) -> only 16'h5555 is ever applied. Separately, load 16'hBEEF exactly on the boundary edge while 16'h1111 is pending -> 16'h1111 is applied; pending stays 1; 16'hBEEF is applied at the next boundary.
4. Sweep bright over 0, 3 and 7 -> digit_on high for 1, 4 and 8 cycles per 8-cycle slot respectively (registered, 1-cycle lag).
5. Deassert en at digit_sel=2 -> next cycle digit_sel=0 and digit_on=0, with no frame_done. A load while OFF keeps pending=1. Re-enable -> scan restarts at digit 0 and the update is applied after 32 cycles.
6. Assert rst asynchronously mid-slot with pending=1 -> all outputs return to reset values without waiting for a clock edge; pending=0.
